dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the MIPS core and a debug/loader requester.
- Debug accesses use a req/ack handshake; the core is frozen by dropping its enable while debug owns the memory.
- Sits between core (o_mem_* / i_mem_rd_data) and the asynchronous-read data memory; drives the core's i_enable.

Parameters:
DATA_WIDTH_P, 32, data bus width
DATA_ADDR_WIDTH_P, 32, memory address width
MAX_BURST_P, 4, max back-to-back debug accesses before the core gets one cycle (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
i_run  in  1  external core run request
o_core_enable  out  1  to core i_enable
i_core_addr  in  DATA_ADDR_WIDTH_P  core o_mem_addr
i_core_wr_en  in  1  core o_mem_wr_en
i_core_wr_data  in  DATA_WIDTH_P  core o_mem_wr_data
o_core_rd_data  out  DATA_WIDTH_P  to core i_mem_rd_data
i_dbg_req  in  1  debug access request (level)
i_dbg_we  in  1  1 = write, 0 = read
i_dbg_addr  in  DATA_ADDR_WIDTH_P  debug address
i_dbg_wr_data  in  DATA_WIDTH_P  debug write data
o_dbg_ack  out  1  one-cycle completion pulse
o_dbg_rd_data  out  DATA_WIDTH_P  registered read data, valid with ack, held until next debug read
o_mem_addr  out  DATA_ADDR_WIDTH_P  to memory
o_mem_wr_en  out  1  to memory
o_mem_wr_data  out  DATA_WIDTH_P  to memory
i_mem_rd_data  in  DATA_WIDTH_P  asynchronous read data from memory

Behaviour:
- States: RUN, DBG, ACK. Reset (reset=0) forces RUN immediately.
- Reset values: burst_cnt=0, captured debug fields=0, o_dbg_rd_data=0, o_dbg_ack=0, o_core_enable=0.
- While reset is low, o_mem_wr_en=0 regardless of inputs.
- o_core_rd_data = i_mem_rd_data combinationally in all states.
- RUN:
  - o_core_enable=i_run.
  - Memory mux selects core inputs; o_mem_wr_en = i_core_wr_en & i_run.
  - i_dbg_req=1 at an edge: capture we/addr/wr_data; go DBG. The core instruction in that cycle still completes.
- DBG (exactly 1 cycle):
  - o_core_enable=0.
  - Memory mux selects the captured debug fields; o_mem_wr_en = captured we.
  - At the edge: write commits; if read, o_dbg_rd_data <= i_mem_rd_data; burst_cnt++; go ACK.
- ACK:
  - o_dbg_ack=1; o_core_enable=0; o_mem_wr_en=0.
  - Requester must drop i_dbg_req this cycle, or present the next access (fields sampled at this edge).
  - If i_dbg_req=1 and (burst_cnt<MAX_BURST_P or i_run=0): capture, go DBG.
  - Otherwise go RUN and clear burst_cnt.
- Latency: req seen in RUN -> ack 2 cycles later. Back-to-back debug accesses: one every 2 cycles.
- Fairness: with i_run=1, after MAX_BURST_P debug accesses the core gets at least one RUN cycle even if req is still high. With i_run=0, no limit.
- A req high in RUN wins over the core for the next cycle; no request is dropped.
- i_run falling during DBG/ACK has no effect on the in-flight access.
- reset mid-access: write not performed if reset is asserted before the DBG edge; no ack issued.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined: adds output o_stall_cycles (32 bits).
  - Counts cycles with i_run=1 and o_core_enable=0; saturates at all-ones.
  - Reset to 0 by reset.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package dmem_arb_pkg: state encoding constants ST_RUN=2'd0, ST_DBG=2'd1, ST_ACK=2'd2.
- Burst-counter width is derived from MAX_BURST_P via clog2(MAX_BURST_P+1).
- No sub-module; mux, FSM and counter fit in one module.

Test Plan:
- Reset low mid-DBG write (addr 84, data 7) -> mem[84] unchanged, state RUN, ack never pulses, all outputs 0.
- i_run=1, no req; core writes 7 to addr 84 -> mem[84]=7; o_core_enable=1 every cycle.
- Debug read addr 84 (mem=7) while i_run=1 -> o_core_enable low for exactly 2 cycles; ack 2 cycles after req; o_dbg_rd_data=7.
- Debug write 0xDEADBEEF to addr 10, then read addr 10 back-to-back in ACK -> second ack 2 cycles after first; rd_data=0xDEADBEEF; core stalled 4 cycles.
- req held high for 6 accesses, MAX_BURST_P=4, i_run=1 -> 4 acks, one RUN cycle with core enabled, then 2 more acks; with i_run=0, 6 acks with no RUN gap.
- DMEM_ARB_STATS_EN build, run the previous scenario -> o_stall_cycles equals the counted disabled cycles with i_run=1 (12 for 6 accesses).

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encodings and
// the saturating increment used by the optional stall counter
// (DMEM_ARB_STATS_EN).
package dmem_arb_pkg;

    localparam logic [1:0] ST_RUN = 2'd0;
    localparam logic [1:0] ST_DBG = 2'd1;
    localparam logic [1:0] ST_ACK = 2'd2;

    localparam int STALL_W = 32;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STALL_W-1:0] sat_inc32(input logic [STALL_W-1:0] v);
        logic [STALL_W-1:0] r;
        if (v == 32'hFFFF_FFFF) begin
            r = v;
        end else begin
            r = v + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Debug/loader access channel into the data-memory arbiter.
// The requester holds req (level) with we/addr/wr_data until ack pulses;
// rd_data is registered inside the arbiter and held until the next read.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH_P      = 32,
    parameter int DATA_ADDR_WIDTH_P = 32
);
    logic                         req;
    logic                         we;
    logic [DATA_ADDR_WIDTH_P-1:0] addr;
    logic [DATA_WIDTH_P-1:0]      wr_data;
    logic                         ack;
    logic [DATA_WIDTH_P-1:0]      rd_data;

    modport master (
        output req, we, addr, wr_data,
        input  ack, rd_data
    );

    modport slave (
        input  req, we, addr, wr_data,
        output ack, rd_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the MIPS core and a debug/loader
// requester. The core is frozen (enable low) while a debug access owns the
// memory; each debug access takes a DBG cycle followed by an ACK cycle.
// A burst limit guarantees the running core a cycle every MAX_BURST_P
// debug accesses. Optional macro DMEM_ARB_STATS_EN adds o_stall_cycles.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH_P      = 32,
    parameter int DATA_ADDR_WIDTH_P = 32,
    parameter int MAX_BURST_P       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_run,
    output logic                         o_core_enable,
    input  logic [DATA_ADDR_WIDTH_P-1:0] i_core_addr,
    input  logic                         i_core_wr_en,
    input  logic [DATA_WIDTH_P-1:0]      i_core_wr_data,
    output logic [DATA_WIDTH_P-1:0]      o_core_rd_data,
    dmem_arbiter_if.slave                dbg_if,
    output logic [DATA_ADDR_WIDTH_P-1:0] o_mem_addr,
    output logic                         o_mem_wr_en,
    output logic [DATA_WIDTH_P-1:0]      o_mem_wr_data,
    input  logic [DATA_WIDTH_P-1:0]      i_mem_rd_data
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [STALL_W-1:0]           o_stall_cycles
`endif
);

    localparam int CNT_W = $clog2(MAX_BURST_P + 1);
    localparam logic [CNT_W-1:0] MAX_CNT_C = CNT_W'(MAX_BURST_P);

    logic [1:0]                   r_state;
    logic [CNT_W-1:0]             r_burst_cnt;
    logic                         r_cap_we;
    logic [DATA_ADDR_WIDTH_P-1:0] r_cap_addr;
    logic [DATA_WIDTH_P-1:0]      r_cap_wr_data;
    logic [DATA_WIDTH_P-1:0]      r_dbg_rd_data;
    logic                         r_dbg_ack;

    logic [1:0] w_state_nxt;
    logic       w_capture;
    logic       w_burst_ok;

    assign w_burst_ok = (r_burst_cnt < MAX_CNT_C);

    // Next-state decode and debug-field capture strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (dbg_if.req) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_DBG;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DBG: begin
                w_state_nxt = ST_ACK;
            end
            ST_ACK: begin
                // A stopped core has no claim on the memory, so the limit only
                // applies while it is asking to run.
                if (dbg_if.req && (w_burst_ok || !i_run)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_DBG;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // FSM state register and the ack pulse issued on entry to ACK.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_RUN;
            r_dbg_ack <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dbg_ack <= (r_state == ST_DBG);
        end
    end

    // Latch the debug request fields when an access is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cap_we      <= 1'b0;
            r_cap_addr    <= '0;
            r_cap_wr_data <= '0;
        end else if (w_capture) begin
            r_cap_we      <= dbg_if.we;
            r_cap_addr    <= dbg_if.addr;
            r_cap_wr_data <= dbg_if.wr_data;
        end else begin
            r_cap_we      <= r_cap_we;
            r_cap_addr    <= r_cap_addr;
            r_cap_wr_data <= r_cap_wr_data;
        end
    end

    // Burst counter: counts accesses in the current burst, saturating at the
    // limit so an unbounded burst with the core stopped cannot wrap it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_burst_cnt <= '0;
        end else if (r_state == ST_DBG) begin
            if (r_burst_cnt != MAX_CNT_C) begin
                r_burst_cnt <= r_burst_cnt + CNT_W'(1'b1);
            end else begin
                r_burst_cnt <= r_burst_cnt;
            end
        end else if ((r_state == ST_ACK) && (w_state_nxt == ST_RUN)) begin
            r_burst_cnt <= '0;
        end else begin
            r_burst_cnt <= r_burst_cnt;
        end
    end

    // Register debug read data at the end of a DBG read; held otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dbg_rd_data <= '0;
        end else if ((r_state == ST_DBG) && !r_cap_we) begin
            r_dbg_rd_data <= i_mem_rd_data;
        end else begin
            r_dbg_rd_data <= r_dbg_rd_data;
        end
    end

    // Memory port mux: debug owns the port only during DBG; writes are
    // suppressed while reset is low so an interrupted access never commits.
    always_comb begin
        o_mem_addr    = i_core_addr;
        o_mem_wr_data = i_core_wr_data;
        o_mem_wr_en   = 1'b0;
        if (r_state == ST_DBG) begin
            o_mem_addr    = r_cap_addr;
            o_mem_wr_data = r_cap_wr_data;
            o_mem_wr_en   = r_cap_we & reset;
        end else begin
            o_mem_addr    = i_core_addr;
            o_mem_wr_data = i_core_wr_data;
            o_mem_wr_en   = (r_state == ST_RUN) & i_core_wr_en & i_run & reset;
        end
    end

    assign o_core_enable  = (r_state == ST_RUN) & i_run & reset;
    assign o_core_rd_data = i_mem_rd_data;
    assign dbg_if.ack     = r_dbg_ack;
    assign dbg_if.rd_data = r_dbg_rd_data;

`ifdef DMEM_ARB_STATS_EN
    logic [STALL_W-1:0] r_stall_cycles;

    // Count cycles where the core wants to run but is held off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
        end else if (i_run && !o_core_enable) begin
            r_stall_cycles <= sat_inc32(r_stall_cycles);
        end else begin
            r_stall_cycles <= r_stall_cycles;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with an asynchronous-read memory
// model. Inputs change on the falling edge; outputs are checked 1 time unit
// later, well before the next rising edge.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_run;
    logic        o_core_enable;
    logic [31:0] i_core_addr;
    logic        i_core_wr_en;
    logic [31:0] i_core_wr_data;
    logic [31:0] o_core_rd_data;
    logic [31:0] o_mem_addr;
    logic        o_mem_wr_en;
    logic [31:0] o_mem_wr_data;
    logic [31:0] i_mem_rd_data;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] o_stall_cycles;
    logic [31:0] stall0;
`endif

    int n_checks = 0;
    int n_err    = 0;

    dmem_arbiter_if #(.DATA_WIDTH_P(32), .DATA_ADDR_WIDTH_P(32)) dbg ();

    dmem_arbiter #(
        .DATA_WIDTH_P(32), .DATA_ADDR_WIDTH_P(32), .MAX_BURST_P(4)
    ) dut (
        .clk(clk), .reset(reset), .i_run(i_run), .o_core_enable(o_core_enable),
        .i_core_addr(i_core_addr), .i_core_wr_en(i_core_wr_en),
        .i_core_wr_data(i_core_wr_data), .o_core_rd_data(o_core_rd_data),
        .dbg_if(dbg.slave),
        .o_mem_addr(o_mem_addr), .o_mem_wr_en(o_mem_wr_en),
        .o_mem_wr_data(o_mem_wr_data), .i_mem_rd_data(i_mem_rd_data)
`ifdef DMEM_ARB_STATS_EN
        , .o_stall_cycles(o_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: synchronous write, asynchronous read, 256 words.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (o_mem_wr_en) mem[o_mem_addr[7:0]] <= o_mem_wr_data;
    end
    assign i_mem_rd_data = mem[o_mem_addr[7:0]];

    typedef struct {
        logic        run;
        logic        cwe;
        logic [31:0] caddr;
        logic [31:0] cwd;
        logic        req;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwd;
        logic        en;
        logic        ack;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] crd;
        logic [31:0] drd;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(
        input logic run, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwd,
        input logic req, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd,
        input logic en, input logic ack, input logic mwe, input logic [31:0] maddr,
        input logic [31:0] crd, input logic [31:0] drd);
        vec_t v;
        v.run = run; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.req = req; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
        v.en = en; v.ack = ack; v.mwe = mwe; v.maddr = maddr; v.crd = crd; v.drd = drd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic run, input logic req, input logic dwe,
                         input logic [31:0] daddr, input logic [31:0] dwd);
        i_run = run; dbg.req = req; dbg.we = dwe; dbg.addr = daddr; dbg.wr_data = dwd;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        reset = 1'b0;
        i_core_addr = 32'd0; i_core_wr_en = 1'b1; i_core_wr_data = 32'd5;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

        // Reset state: everything quiet even with run and core write asserted.
        @(negedge clk); #1;
        chk("rst_en", {31'd0, o_core_enable}, 32'd0);
        chk("rst_ack", {31'd0, dbg.ack}, 32'd0);
        chk("rst_mwe", {31'd0, o_mem_wr_en}, 32'd0);
        chk("rst_drd", dbg.rd_data, 32'd0);
`ifdef DMEM_ARB_STATS_EN
        chk("rst_stall", o_stall_cycles, 32'd0);
`endif

        // Reset asserted in the middle of a DBG write to addr 84.
        @(negedge clk);
        reset = 1'b1; i_core_wr_en = 1'b0; i_core_wr_data = 32'd0;
        drive(1'b1, 1'b1, 1'b1, 32'd84, 32'd7);
        #1 chk("mr_run_en", {31'd0, o_core_enable}, 32'd1);
        @(negedge clk); #1;
        chk("mr_dbg_mwe", {31'd0, o_mem_wr_en}, 32'd1);
        chk("mr_dbg_addr", o_mem_addr, 32'd84);
        chk("mr_dbg_en", {31'd0, o_core_enable}, 32'd0);
        reset = 1'b0; #1;
        chk("mr_rst_mwe", {31'd0, o_mem_wr_en}, 32'd0);
        chk("mr_rst_ack", {31'd0, dbg.ack}, 32'd0);
        chk("mr_rst_drd", dbg.rd_data, 32'd0);
        @(negedge clk);
        dbg.req = 1'b0; #1;
        chk("mr_mem84", mem[84], 32'd0);
        chk("mr_ack2", {31'd0, dbg.ack}, 32'd0);
        chk("mr_en2", {31'd0, o_core_enable}, 32'd0);
        @(negedge clk);
        reset = 1'b1; #1;
        chk("mr_back_run", {31'd0, o_core_enable}, 32'd1);
        chk("mr_ack3", {31'd0, dbg.ack}, 32'd0);
        @(negedge clk);

        //            run  cwe  caddr  cwd   req  dwe  daddr  dwd            en   ack  mwe  maddr  crd            drd
        vecs[0]  = mk(1'b1,1'b1,32'd84,32'd7, 1'b0,1'b0,32'd0, 32'd0,         1'b1,1'b0,1'b1,32'd84,32'd0,         32'd0);
        vecs[1]  = mk(1'b1,1'b0,32'd84,32'd0, 1'b0,1'b0,32'd0, 32'd0,         1'b1,1'b0,1'b0,32'd84,32'd7,         32'd0);
        vecs[2]  = mk(1'b1,1'b0,32'd0, 32'd0, 1'b1,1'b0,32'd84,32'd0,         1'b1,1'b0,1'b0,32'd0, 32'd0,         32'd0);
        vecs[3]  = mk(1'b1,1'b0,32'd0, 32'd0, 1'b1,1'b0,32'd84,32'd0,         1'b0,1'b0,1'b0,32'd84,32'd7,         32'd0);
        vecs[4]  = mk(1'b1,1'b0,32'd0, 32'd0, 1'b0,1'b0,32'd0, 32'd0,         1'b0,1'b1,1'b0,32'd0, 32'd0,         32'd7);
        vecs[5]  = mk(1'b1,1'b0,32'd0, 32'd0, 1'b0,1'b0,32'd0, 32'd0,         1'b1,1'b0,1'b0,32'd0, 32'd0,         32'd7);
        vecs[6]  = mk(1'b1,1'b0,32'd0, 32'd0, 1'b1,1'b1,32'd10,32'hDEADBEEF,  1'b1,1'b0,1'b0,32'd0, 32'd0,         32'd7);
        vecs[7]  = mk(1'b1,1'b0,32'd0, 32'd0, 1'b1,1'b1,32'd10,32'hDEADBEEF,  1'b0,1'b0,1'b1,32'd10,32'd0,         32'd7);
        vecs[8]  = mk(1'b1,1'b0,32'd0, 32'd0, 1'b1,1'b0,32'd10,32'd0,         1'b0,1'b1,1'b0,32'd0, 32'd0,         32'd7);
        vecs[9]  = mk(1'b1,1'b0,32'd0, 32'd0, 1'b1,1'b0,32'd10,32'd0,         1'b0,1'b0,1'b0,32'd10,32'hDEADBEEF,  32'd7);
        vecs[10] = mk(1'b1,1'b0,32'd0, 32'd0, 1'b0,1'b0,32'd0, 32'd0,         1'b0,1'b1,1'b0,32'd0, 32'd0,         32'hDEADBEEF);
        vecs[11] = mk(1'b1,1'b0,32'd0, 32'd0, 1'b0,1'b0,32'd0, 32'd0,         1'b1,1'b0,1'b0,32'd0, 32'd0,         32'hDEADBEEF);

        for (int i = 0; i < 12; i++) begin
            i_core_wr_en = vecs[i].cwe; i_core_addr = vecs[i].caddr; i_core_wr_data = vecs[i].cwd;
            drive(vecs[i].run, vecs[i].req, vecs[i].dwe, vecs[i].daddr, vecs[i].dwd);
            #1;
            chk($sformatf("v%0d_en", i),    {31'd0, o_core_enable}, {31'd0, vecs[i].en});
            chk($sformatf("v%0d_ack", i),   {31'd0, dbg.ack},       {31'd0, vecs[i].ack});
            chk($sformatf("v%0d_mwe", i),   {31'd0, o_mem_wr_en},   {31'd0, vecs[i].mwe});
            chk($sformatf("v%0d_maddr", i), o_mem_addr,             vecs[i].maddr);
            chk($sformatf("v%0d_crd", i),   o_core_rd_data,         vecs[i].crd);
            chk($sformatf("v%0d_drd", i),   dbg.rd_data,            vecs[i].drd);
            @(negedge clk);
        end

        // Fairness with i_run=1: 4 accesses, one enabled RUN cycle, 2 more.
        i_core_wr_en = 1'b0; i_core_addr = 32'd0;
`ifdef DMEM_ARB_STATS_EN
        stall0 = o_stall_cycles;
`endif
        for (int c = 0; c < 15; c++) begin
            drive(1'b1, (c < 13), 1'b0, 32'd10, 32'd0);
            #1;
            chk($sformatf("fr1_c%0d_en", c), {31'd0, o_core_enable},
                ((c == 0) || (c == 9) || (c == 14)) ? 32'd1 : 32'd0);
            chk($sformatf("fr1_c%0d_ack", c), {31'd0, dbg.ack},
                ((c == 2) || (c == 4) || (c == 6) || (c == 8) || (c == 11) || (c == 13)) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        chk("fr1_drd", dbg.rd_data, 32'hDEADBEEF);
`ifdef DMEM_ARB_STATS_EN
        chk("fr1_stall", o_stall_cycles - stall0, 32'd12);
        stall0 = o_stall_cycles;
`endif

        // With i_run=0 there is no burst limit: 6 acks, one every 2 cycles.
        for (int c = 0; c < 14; c++) begin
            drive(1'b0, (c < 12), 1'b0, 32'd10, 32'd0);
            #1;
            chk($sformatf("fr0_c%0d_en", c), {31'd0, o_core_enable}, 32'd0);
            chk($sformatf("fr0_c%0d_ack", c), {31'd0, dbg.ack},
                ((c >= 2) && (c <= 12) && ((c % 2) == 0)) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        #1 chk("fr0_back_run", {31'd0, o_core_enable}, 32'd1);
`ifdef DMEM_ARB_STATS_EN
        chk("fr0_stall", o_stall_cycles - stall0, 32'd0);
`endif
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
